// File: rtl/grf.sv
// grf: 32x32 register file, two async read ports, one sync write port, same-cycle write bypass
module grf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [NREG-1:0]   WrOneHot
);
    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   dec;
    logic              wr;
    always_comb begin
        dec = '0;
        for (int i = 1; i < NREG; i++)
            dec[i] = WE & (A3 == ADDR_W'(i));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            WrOneHot <= '0;
        end else begin
            for (int i = 1; i < NREG; i++)
                if (dec[i])
                    regs[i] <= WD;
            WrOneHot <= dec;
        end
    end
    // Bypass only when the write will actually commit this edge
    assign wr  = WE & ~reset;
    assign RD1 = (A1 == '0) ? '0 : (wr && A3 == A1) ? WD : regs[A1];
    assign RD2 = (A2 == '0) ? '0 : (wr && A3 == A2) ? WD : regs[A2];
endmodule

// File: tb/tb_grf.sv
// tb_grf: randomized and directed checks of grf against an array-based register model
module tb_grf;
    logic        clk = 0;
    logic        reset, WE;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD, RD1, RD2, WrOneHot;
    logic [31:0] model [32];
    logic [31:0] exp_oh;
    int total = 0, bad = 0;

    grf dut (.clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
             .WD(WD), .RD1(RD1), .RD2(RD2), .WrOneHot(WrOneHot));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 0) return 0;
        if (WE && !reset && A3 == a) return WD;
        return model[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            foreach (model[i]) model[i] = 0;
            exp_oh = 0;
        end else if (WE && A3 != 0) begin
            model[A3] = WD;
            exp_oh = 32'd1 << A3;
        end else
            exp_oh = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; WE = 0; A1 = 0; A2 = 0; A3 = 0; WD = 0;
        tick();
        reset = 0; WE = 1; A3 = 5; WD = 32'hDEADBEEF;
        tick();
        reset = 1; WE = 1; A3 = 5; WD = 32'h1; A1 = 5;
        tick();
        reset = 0; WE = 0; #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h exp=%h", RD1, 32'h0); end
        total++; if (WrOneHot !== 32'h0) begin bad++; $display("FAIL reset_oh got=%h exp=%h", WrOneHot, 32'h0); end
    endtask

    task automatic test_basic();
        WE = 1; A3 = 8; WD = 32'h12345678;
        tick();
        WE = 0; A1 = 8; A2 = 0; #1;
        total++; if (RD1 !== 32'h12345678) begin bad++; $display("FAIL basic_rd1 got=%h exp=%h", RD1, 32'h12345678); end
        total++; if (RD2 !== 32'h0) begin bad++; $display("FAIL basic_rd2 got=%h exp=%h", RD2, 32'h0); end
        total++; if (WrOneHot !== 32'h0000_0100) begin bad++; $display("FAIL basic_oh got=%h exp=%h", WrOneHot, 32'h100); end
        tick();
        total++; if (WrOneHot !== 32'h0) begin bad++; $display("FAIL basic_oh_clear got=%h exp=%h", WrOneHot, 32'h0); end
    endtask

    task automatic test_zero();
        WE = 1; A3 = 0; WD = 32'hFFFFFFFF; A1 = 0; #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL zero_same got=%h exp=%h", RD1, 32'h0); end
        tick();
        WE = 0; #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL zero_next got=%h exp=%h", RD1, 32'h0); end
        total++; if (WrOneHot !== 32'h0) begin bad++; $display("FAIL zero_oh got=%h exp=%h", WrOneHot, 32'h0); end
    endtask

    task automatic test_bypass();
        WE = 1; A3 = 9; WD = 32'h11;
        tick();
        WE = 1; A3 = 9; WD = 32'h22; A1 = 9; A2 = 9; #1;
        total++; if (RD1 !== 32'h22) begin bad++; $display("FAIL byp_rd1 got=%h exp=%h", RD1, 32'h22); end
        total++; if (RD2 !== 32'h22) begin bad++; $display("FAIL byp_rd2 got=%h exp=%h", RD2, 32'h22); end
        tick();
        WE = 0; #1;
        total++; if (RD1 !== 32'h22) begin bad++; $display("FAIL byp_stored got=%h exp=%h", RD1, 32'h22); end
    endtask

    task automatic test_reset_bypass();
        reset = 1; WE = 1; A3 = 9; WD = 32'h33; A1 = 9; #1;
        total++; if (RD1 !== 32'h22) begin bad++; $display("FAIL rstbyp_during got=%h exp=%h", RD1, 32'h22); end
        tick();
        reset = 0; WE = 0; #1;
        total++; if (RD1 !== 32'h0) begin bad++; $display("FAIL rstbyp_after got=%h exp=%h", RD1, 32'h0); end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) begin
            WE = 1; A3 = 5'(i); WD = i * 32'h01010101;
            tick();
            total++; if (WrOneHot !== (32'd1 << i)) begin bad++; $display("FAIL sweep_oh[%0d] got=%h exp=%h", i, WrOneHot, 32'd1 << i); end
        end
        WE = 0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i); #1;
            total++; if (RD1 !== i * 32'h01010101) begin bad++; $display("FAIL sweep_rd1[%0d] got=%h exp=%h", i, RD1, i * 32'h01010101); end
            total++; if (RD2 !== (31 - i) * 32'h01010101) begin bad++; $display("FAIL sweep_rd2[%0d] got=%h exp=%h", i, RD2, (31 - i) * 32'h01010101); end
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            WE = $urandom_range(0, 1);
            A1 = 5'($urandom); A2 = ($urandom_range(0, 3) == 0) ? A1 : 5'($urandom);
            A3 = ($urandom_range(0, 2) == 0) ? A1 : 5'($urandom);
            WD = $urandom;
            #1;
            e1 = rd(A1); e2 = rd(A2);
            total++; if (RD1 !== e1) begin bad++; $display("FAIL rand_rd1[%0d] got=%h exp=%h", n, RD1, e1); end
            total++; if (RD2 !== e2) begin bad++; $display("FAIL rand_rd2[%0d] got=%h exp=%h", n, RD2, e2); end
            tick();
            total++; if (WrOneHot !== exp_oh) begin bad++; $display("FAIL rand_oh[%0d] got=%h exp=%h", n, WrOneHot, exp_oh); end
        end
        reset = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_reset_bypass();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grf.md
Name: grf

Overview:
- General register file for the pipelined MIPS core: 32 x 32-bit registers, two asynchronous read ports (D stage), one synchronous write port (W stage).
- The write port is the distribution side of the datapath selectors. One write-data bus is decoded by a 5-bit address into a one-hot enable over the 32 registers.
- Internal W-to-D bypass: a value written in cycle N is visible on the read ports in the same cycle N. The D-stage forwarding muxes therefore need no W-stage input.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers; always 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- WE  in  1  write enable (W stage).
- A1  in  ADDR_W  read address, port 1 (rs).
- A2  in  ADDR_W  read address, port 2 (rt).
- A3  in  ADDR_W  write address (rd/rt/31, already selected upstream).
- WD  in  DATA_W  write data.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- WrOneHot  out  NREG  registered one-hot of the last committed write; 0 if the last cycle committed none.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and reset.
- Reset:
  - If reset=1 at a posedge, all 32 registers and WrOneHot become 0.
  - Any WE in that same cycle is discarded.
  - Reset has priority over writes at every edge.
- Write decode:
  - Combinational one-hot dec[i] = WE & (A3==i) & (i!=0).
  - On a posedge with reset=0, register i <= WD where dec[i]=1. All other registers hold.
  - WrOneHot <= dec, registered.
- $0:
  - Register 0 is hardwired 0 and never written.
  - dec[0] is always 0.
  - WE with A3=0 commits nothing and leaves WrOneHot = 0 the next cycle.
- Read, fully combinational, zero latency:
  - RDk = 0 if Ak==0.
  - Else RDk = WD if (WE & ~reset & A3==Ak).
  - Else RDk = reg[Ak].
- Bypass is suppressed while reset=1. Because the register array clears at the end of the reset cycle, RD reflects the stored pre-reset values during that cycle and 0 afterwards.
- Both ports may address the same register. Both get identical data, bypassed or not.
- Read-after-write across cycles: a value written at edge N reads back from storage in cycle N+1 with no bypass needed.
- Writes of X/any data width: WD is stored as-is with no extension. The upstream selector is responsible for sign/zero extension.
- No X on outputs after the first reset. Before the first reset, register contents are undefined and the bench must not check them.

Test Plan:
- Reset clears everything: write 0xDEADBEEF to $5, then assert reset for 1 cycle with WE=1, A3=5, WD=0x1 → next cycle RD1(A1=5)=0 and WrOneHot=0.
- Basic write/read: WE=1, A3=8, WD=0x12345678 at edge 1. Then WE=0, A1=8, A2=0 → RD1=0x12345678, RD2=0, WrOneHot=32'h0000_0100 for one cycle, then 0.
- $0 immunity: WE=1, A3=0, WD=0xFFFFFFFF → A1=0 reads 0 in the same cycle and the next; WrOneHot=0 next cycle.
- Same-cycle bypass: $9 holds 0x11; drive WE=1, A3=9, WD=0x22, A1=A2=9 → RD1=RD2=0x22 combinationally before the edge, and 0x22 from storage after it.
- Reset suppresses bypass: $9=0x22; drive reset=1, WE=1, A3=9, WD=0x33, A1=9 → RD1=0x22 during the cycle, 0 after the edge.
- Exhaustive sweep: write i*0x01010101 to each $1..$31 on consecutive cycles, checking WrOneHot=(1<<i) each following cycle. Then read all pairs (A1=i, A2=31-i) → expected values, with $0 reading 0.
